// File: rtl/pu.sv
// -----------------------------------------------------------------------------
// pu -- processing unit: one multiply-accumulate cell of the TPU array.
//
// On every enabled rising edge of clk the cell forms a*b at full 2*DATA_WIDTH
// precision (unsigned), adds it to the accumulator at 2*DATA_WIDTH+1 bits and
// writes back f(sum). P is the accumulator register itself, so there is no
// combinational path from a, b or en to P. Latency is one cycle.
//
// Configuration macro: PU_SATURATE_EN
//   undefined (default) : f keeps the low DATA_WIDTH bits (modulo wrap)
//   defined             : f clamps to 2^DATA_WIDTH-1 when the full sum
//                         does not fit in DATA_WIDTH bits
//   Ports and timing are identical in both builds.
//
// Ports
//   clk    in   1           rising-edge clock
//   reset  in   1           synchronous active-high reset, priority over en
//   en     in   1           accumulate enable; en=0 holds the accumulator
//   a      in   DATA_WIDTH  operand A, unsigned
//   b      in   DATA_WIDTH  operand B, unsigned
//   P      out  DATA_WIDTH  registered accumulator value
// -----------------------------------------------------------------------------
module pu #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] P
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;      // full product width
    localparam int SW = 2 * DATA_WIDTH + 1;  // full sum width

    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_d;
    logic [PW-1:0] prod;
    logic [SW-1:0] sum_full;
    logic [W-1:0]  acc_f;

    // Operands are zero-extended so the multiply is unsigned and full width.
    assign prod     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign sum_full = {1'b0, prod} + {{(W + 1){1'b0}}, acc_q};

`ifdef PU_SATURATE_EN
    // Any set bit above the low W bits means the true sum exceeds 2^W-1,
    // including the case where only the product's upper half is non-zero.
    logic overflow;
    assign overflow = |sum_full[SW-1:W];
    assign acc_f    = overflow ? {W{1'b1}} : sum_full[W-1:0];
`else
    // Wrap-around: the upper sum bits are intentionally discarded.
    logic unused_sum_upper;
    assign unused_sum_upper = ^sum_full[SW-1:W];
    assign acc_f            = sum_full[W-1:0];
`endif

    // Next-state selection; reset is applied in the register process so it
    // always wins over en.
    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = acc_f;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign P = acc_q;

endmodule

// File: tb/tb_pu.sv
// -----------------------------------------------------------------------------
// tb_pu -- self-checking bench for pu (DATA_WIDTH = 16).
// Directed vector table, a hand-written idle/reset sequence, then randomized
// traffic checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_pu;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         en;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] P;

    int n_compared;
    int n_mismatched;

    pu #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .a     (a),
        .b     (b),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         en;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_p;
        string        name;
    } vec_t;

    vec_t vecs[$];

`ifdef PU_SATURATE_EN
    localparam logic [W-1:0] EXP_OVF   = 16'hFFFF;
    localparam logic [W-1:0] EXP_BIG   = 16'hFFFF;
    localparam logic [W-1:0] EXP_HALF  = 16'hFFFF;
    localparam logic [W-1:0] EXP_WRAP1 = 16'hFFFF;
    localparam bit           SAT       = 1'b1;
`else
    localparam logic [W-1:0] EXP_OVF   = 16'h0001;
    localparam logic [W-1:0] EXP_BIG   = 16'h0001;
    localparam logic [W-1:0] EXP_HALF  = 16'h0000;
    localparam logic [W-1:0] EXP_WRAP1 = 16'h0000;
    localparam bit           SAT       = 1'b0;
`endif

    task automatic add_vec(input logic r, input logic e, input logic [W-1:0] va,
                           input logic [W-1:0] vb, input logic [W-1:0] ex,
                           input string nm);
        vec_t v;
        v.rst = r; v.en = e; v.a = va; v.b = vb; v.exp_p = ex; v.name = nm;
        vecs.push_back(v);
    endtask

    // Apply inputs away from the edge, let one rising edge pass, sample #1 later.
    task automatic step(input logic r, input logic e, input logic [W-1:0] va,
                        input logic [W-1:0] vb);
        @(negedge clk);
        reset = r; en = e; a = va; b = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [W-1:0] exp_p);
        n_compared++;
        if (P !== exp_p) begin
            n_mismatched++;
            $display("FAIL %s: P=0x%04h expected 0x%04h", nm, P, exp_p);
        end else begin
            $display("ok   %s: P=0x%04h", nm, P);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    longint unsigned model_acc;

    function automatic longint unsigned model_next(input longint unsigned acc,
                                                   input logic r, input logic e,
                                                   input logic [W-1:0] va,
                                                   input logic [W-1:0] vb);
        longint unsigned s;
        if (r) return 0;
        if (!e) return acc;
        s = acc + longint'(va) * longint'(vb);
        if (SAT) return (s > 65535) ? 65535 : s;
        return s % 65536;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return '0;
            1:       return 16'hFFFF;
            2:       return 16'd1;
            3, 4:    return W'($urandom_range(0, 255));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset = 1'b1; en = 1'b0; a = '0; b = '0;

        // ---------------- directed vector table ----------------
        add_vec(1, 0, 0, 0, 16'd0,     "reset");
        add_vec(0, 0, 0, 0, 16'd0,     "idle_after_reset_1");
        add_vec(0, 0, 0, 0, 16'd0,     "idle_after_reset_2");
        add_vec(0, 1, 1, 2, 16'd2,     "mac_1x2");
        add_vec(0, 1, 1, 1, 16'd3,     "mac_1x1");
        add_vec(0, 1, 0, 1, 16'd3,     "mac_0x1");
        add_vec(0, 0, 5, 5, 16'd3,     "hold_1");
        add_vec(0, 0, 5, 5, 16'd3,     "hold_2");
        add_vec(0, 0, 5, 5, 16'd3,     "hold_3");
        add_vec(0, 1, 5, 5, 16'd28,    "mac_5x5");
        add_vec(1, 1, 4, 4, 16'd0,     "reset_over_en");
        add_vec(0, 1, 2, 3, 16'd6,     "resume_2x3");
        add_vec(1, 0, 0, 0, 16'd0,     "reset_ovf");
        add_vec(0, 1, 16'hFFFE, 1, 16'hFFFE, "load_fffe");
        add_vec(0, 1, 1, 3, EXP_OVF,   "overflow_1x3");
        add_vec(1, 0, 0, 0, 16'd0,     "reset_big");
        add_vec(0, 1, 16'hFFFF, 16'hFFFF, EXP_BIG, "big_product");
        add_vec(1, 0, 0, 0, 16'd0,     "reset_half");
        add_vec(0, 1, 16'h0100, 16'h0100, EXP_HALF, "product_upper_only");
        add_vec(1, 0, 0, 0, 16'd0,     "reset_wrap");
        add_vec(0, 1, 16'hFFFF, 1, 16'hFFFF, "load_ffff");
        add_vec(0, 1, 1, 1, EXP_WRAP1, "wrap_ffff_plus_1");
        add_vec(0, 1, 0, 16'hFFFF, EXP_WRAP1, "mul_zero_at_max");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].a, vecs[i].b);
            check(vecs[i].name, vecs[i].exp_p);
        end

        // ---------------- hand sequence: mid-stream reset ----------------
        step(1, 0, 0, 0);
        step(0, 1, 16'd10, 16'd10);   check("seq_acc_100", 16'd100);
        step(0, 1, 16'd7,  16'd3);    check("seq_acc_121", 16'd121);
        step(1, 1, 16'd9,  16'd9);    check("seq_reset_mid", 16'd0);
        step(0, 0, 16'd9,  16'd9);    check("seq_idle_a", 16'd0);
        step(0, 0, 16'd1,  16'd1);    check("seq_idle_b", 16'd0);
        step(0, 1, 16'd4,  16'd5);    check("seq_resume_20", 16'd20);

        // ---------------- randomized vs reference model ----------------
        step(1, 0, 0, 0);
        model_acc = 0;
        check("rand_reset", 16'd0);
        for (int i = 0; i < 400; i++) begin
            logic         r, e;
            logic [W-1:0] ra, rb;
            r  = ($urandom_range(0, 29) == 0);
            e  = ($urandom_range(0, 9) < 7);
            ra = rand_operand();
            rb = rand_operand();
            step(r, e, ra, rb);
            model_acc = model_next(model_acc, r, e, ra, rb);
            check($sformatf("rand_%0d r=%0d en=%0d a=%04h b=%04h", i, r, e, ra, rb),
                  W'(model_acc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
